regfile_pbank: RTL
==================

# regfile_pbank

Parametrised general-purpose register bank for the 16-bit CPU datapath. It has 2**ADDR_W registers of DATA_W bits, one synchronous write port fed from the ALU result, and two registered read ports (rd, rs) with a read-request/valid handshake. Same-cycle write-to-read bypass and a synchronous bank clear are included. A registered monitor output drives the board LEDs. It sits between the control unit (addresses, enables) and the ALU (operands in, result back).

## Interface
- DATA_W, 16, register and data-path width
- ADDR_W, 2, register address width; register count NREG = 2**ADDR_W
- MON_REG, 1, index of the register mirrored on led_out; must be < NREG

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of all registers
- w_en  in  1  write enable
- w_addr  in  ADDR_W  write register index
- source_in  in  DATA_W  write data (ALU result)
- rd_req  in  1  read request; samples rd and rs
- rd  in  ADDR_W  first read index
- rs  in  ADDR_W  second read index
- rd_q  out  DATA_W  registered first operand
- rs_q  out  DATA_W  registered second operand
- q_valid  out  1  operands valid; one-cycle pulse
- led_out  out  DATA_W  registered copy of register MON_REG

## Operation
- Storage: NREG x DATA_W flops. No RAM inference is required.
- Write:
  - On a rising edge with w_en=1 and clr=0, mem[w_addr] <= source_in.
  - With w_en=0, all registers hold their values.
- Clear:
  - On a rising edge with clr=1, all registers go to 0, rd_q/rs_q/led_out go to 0 and q_valid goes to 0.
  - clr has priority over w_en and rd_req; the write and the read in that cycle are dropped.
- Read:
  - On a rising edge with rd_req=1 and clr=0: rd_q <= value(rd), rs_q <= value(rs), q_valid <= 1.
  - With rd_req=0: rd_q and rs_q hold their values and q_valid <= 0.
- Bypass:
  - value(a) = source_in when w_en=1 and w_addr==a; otherwise value(a) = mem[a].
  - A read in the same cycle as a write to the same index therefore returns the new data.
  - rd==rs is legal; both outputs get the same value.
- Monitor: every edge with clr=0, led_out <= value(MON_REG), so the bypass applies to it as well.
- There is no error state. Every address in 0..NREG-1 is valid, and out-of-range addresses cannot occur.

## Timing
- Reset (rst=0, asynchronous): all registers, rd_q, rs_q and led_out are 0; q_valid is 0. Reset takes effect immediately and is released synchronously to clk by the system.
- Reset asserted mid-operation aborts any write or read in progress. After release, the first edge behaves like a normal cycle.
- Write latency: data is in mem after 1 edge. A read issued on the next cycle sees it from storage; a read in the same cycle sees it via the bypass.
- Read latency: 1 cycle. rd_req at edge N gives rd_q/rs_q/q_valid valid after edge N.
- q_valid stays high for consecutive cycles when rd_req is held high (back-to-back reads, one result per cycle).
- led_out lags register contents by 0 cycles relative to a write edge (bypassed) and is updated every cycle.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - Register 0 is hardwired to zero.
  - Writes with w_addr==0 are ignored, and the bypass never forwards for index 0.
  - value(0) = 0 always, including led_out when MON_REG==0.
- REGFILE_ZERO_REG_EN undefined: register 0 is a normal read/write register.

## Test plan
- Reset: hold rst=0 with random inputs toggling -> rd_q=rs_q=led_out=0x0000 and q_valid=0 throughout. After release with rd_req=1, rd=2, rs=3 -> outputs 0x0000 with q_valid=1.
- Write/read: write 0x1234 to r2, then 0xABCD to r3; next cycle rd_req with rd=2, rs=3 -> rd_q=0x1234, rs_q=0xABCD one cycle later, q_valid single pulse.
- Bypass: r1=0x0005; same cycle w_en=1, w_addr=1, source_in=0x00FF, rd_req=1, rd=1, rs=1 -> rd_q=rs_q=0x00FF, led_out=0x00FF (MON_REG=1).
- Clear priority: r0..r3 loaded non-zero; clr=1 with w_en=1 (w_addr=2, 0x7777) and rd_req=1 -> all registers and outputs 0, q_valid=0. A following read of r2 returns 0x0000.
- Async reset mid-stream: back-to-back reads in progress with q_valid=1; pulse rst low between edges -> outputs drop to 0 immediately without a clock edge, and contents are cleared.
- Zero register (REGFILE_ZERO_REG_EN defined): write 0xFFFF to r0 with rd_req, rd=0 in the same cycle -> rd_q=0x0000, and a later read of r0 also gives 0x0000. Without the macro, the same stimulus gives 0xFFFF.

Source files
------------

// File: rtl/regfile_pbank.sv
// regfile_pbank: NREG x DATA_W register bank with one write port, two registered read ports, write bypass, sync clear and an LED monitor; optional REGFILE_ZERO_REG_EN hardwires r0 to zero.
// Latency: a write lands in storage after 1 edge; rd_q/rs_q/q_valid are valid 1 cycle after rd_req; led_out is refreshed on every edge.
// Backpressure: none; one read result per cycle while rd_req is held, and the consumer must take each q_valid pulse.
module regfile_pbank #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int MON_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] source_in,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  output logic [DATA_W-1:0] rd_q,
  output logic [DATA_W-1:0] rs_q,
  output logic              q_valid,
  output logic [DATA_W-1:0] led_out
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] MON_IDX = ADDR_W'(MON_REG);

  logic [DATA_W-1:0] mem [NREG];

  // Effective write strobe: with the zero register enabled, writes to r0 never
  // reach storage and are never forwarded.
  logic              wr_ok;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] mon_val;

  // Operand value seen by a read this cycle: bypassed write data wins over storage.
  function automatic logic [DATA_W-1:0] fwd_val(
    input logic [ADDR_W-1:0] a,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (we && (wa == a)) begin
      v = wd;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (a == '0) begin
      v = '0;
    end
`endif
    return v;
  endfunction

  // Qualify the write enable and form the three bypassed read values.
  always_comb begin
    wr_ok = w_en;
`ifdef REGFILE_ZERO_REG_EN
    if (w_addr == '0) begin
      wr_ok = 1'b0;
    end
`endif
    rd_val  = fwd_val(rd,      wr_ok, w_addr, source_in, mem[rd]);
    rs_val  = fwd_val(rs,      wr_ok, w_addr, source_in, mem[rs]);
    mon_val = fwd_val(MON_IDX, wr_ok, w_addr, source_in, mem[MON_IDX]);
  end

  // Register storage: async reset, sync clear has priority over the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[w_addr] <= source_in;
    end
  end

  // Read ports: capture operands on rd_req, hold them otherwise; q_valid pulses per request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      rs_q    <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      rd_q    <= '0;
      rs_q    <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= rd_req;
      if (rd_req) begin
        rd_q <= rd_val;
        rs_q <= rs_val;
      end
    end
  end

  // LED monitor: mirrors the monitored register every cycle, including bypassed writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_out <= '0;
    end else if (clr) begin
      led_out <= '0;
    end else begin
      led_out <= mon_val;
    end
  end

endmodule
